// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: widths, flag levels and
// the fetch FSM state encoding.
package inst_fetcher_pkg;

  localparam int   ADDRESS_WIDTH     = 32;
  localparam int   INSTRUCTION_WIDTH = 32;
  localparam logic ENABLE            = 1'b1;
  localparam logic NULL              = 1'b0;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_MISS  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus bundle: cache lookup, memory refill request, instruction
// queue push and commit-side redirect. master = fetcher, slave = environment.
interface inst_fetcher_if
  import inst_fetcher_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_WIDTH,
  parameter int INST_W = INSTRUCTION_WIDTH
);

  logic [ADDR_W-1:0] icache_pc_out;
  logic [INST_W-1:0] icache_inst_in;
  logic              icache_miss_in;
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_pc_out;
  logic              mem_done_in;
  logic              iq_full_in;
  logic              iq_valid_out;
  logic [INST_W-1:0] iq_inst_out;
  logic [ADDR_W-1:0] iq_pc_out;
  logic              clear_in;
  logic [ADDR_W-1:0] clear_pc_in;

  modport master (
    output icache_pc_out, mem_req_out, mem_pc_out,
           iq_valid_out, iq_inst_out, iq_pc_out,
    input  icache_inst_in, icache_miss_in, mem_done_in,
           iq_full_in, clear_in, clear_pc_in
  );

  modport slave (
    input  icache_pc_out, mem_req_out, mem_pc_out,
           iq_valid_out, iq_inst_out, iq_pc_out,
    output icache_inst_in, icache_miss_in, mem_done_in,
           iq_full_in, clear_in, clear_pc_in
  );

endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: looks up pc in the I-cache, pushes hits into the
// instruction queue, and holds a refill request to memory on a miss.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int              ADDR_W   = ADDRESS_WIDTH,
  parameter int              INST_W   = INSTRUCTION_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           rdy_in,
  inst_fetcher_if.master bus
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              iq_valid_q, iq_valid_d;
  logic [INST_W-1:0] iq_inst_q, iq_inst_d;
  logic [ADDR_W-1:0] iq_pc_q, iq_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_pc_q, mem_pc_d;

  // Wraps naturally modulo 2^ADDR_W.
  assign pc_inc = pc_q + ADDR_W'(4);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IF_FETCH;
      pc_q       <= RESET_PC;
      iq_valid_q <= NULL;
      iq_inst_q  <= '0;
      iq_pc_q    <= '0;
      mem_req_q  <= NULL;
      mem_pc_q   <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iq_valid_q <= iq_valid_d;
      iq_inst_q  <= iq_inst_d;
      iq_pc_q    <= iq_pc_d;
      mem_req_q  <= mem_req_d;
      mem_pc_q   <= mem_pc_d;
    end
  end

  // A redirect during MISS parks in DRAIN because the memory controller cannot
  // cancel; the outstanding word must still be waited out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_FETCH: if (!bus.clear_in && bus.icache_miss_in) state_d = IF_MISS;
      IF_MISS: begin
        if (bus.mem_done_in)   state_d = IF_FETCH;
        else if (bus.clear_in) state_d = IF_DRAIN;
      end
      IF_DRAIN: if (bus.mem_done_in) state_d = IF_FETCH;
      default:  state_d = IF_FETCH;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    iq_valid_d = NULL;
    iq_inst_d  = iq_inst_q;
    iq_pc_d    = iq_pc_q;
    mem_req_d  = mem_req_q;
    mem_pc_d   = mem_pc_q;
    if (bus.clear_in) pc_d = bus.clear_pc_in;
    case (state_q)
      IF_FETCH: begin
        if (!bus.clear_in) begin
          if (bus.icache_miss_in) begin
            mem_req_d = ENABLE;
            mem_pc_d  = pc_q;
          end else if (!bus.iq_full_in) begin
            iq_valid_d = ENABLE;
            iq_inst_d  = bus.icache_inst_in;
            iq_pc_d    = pc_q;
            pc_d       = pc_inc;
          end
        end
      end
      IF_MISS, IF_DRAIN: if (bus.mem_done_in) mem_req_d = NULL;
      default:           mem_req_d = NULL;
    endcase
  end

  assign bus.icache_pc_out = pc_q;
  assign bus.mem_req_out   = mem_req_q;
  assign bus.mem_pc_out    = mem_pc_q;
  assign bus.iq_valid_out  = iq_valid_q;
  assign bus.iq_inst_out   = iq_inst_q;
  assign bus.iq_pc_out     = iq_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level fetch model.
module tb_inst_fetcher;

  logic clk;
  logic rst_n;
  logic rdy;

  inst_fetcher_if #(.ADDR_W(32), .INST_W(32)) bus ();

  inst_fetcher #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Cache presence per word slot, shared by the cache stub and the model.
  bit cvalid [1024];

  // Model: pc, one pending refill (address), last pushed instruction.
  logic [31:0] m_pc, m_mpc, m_inst, m_ipc;
  bit          m_req, m_vld;
  int          mcnt = -1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[17:2]};
  endfunction

  function automatic int slot(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_mpc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
    m_req = 1'b0; m_vld = 1'b0;
  endtask

  // One clock of fetch behaviour: a pending refill blocks fetching until its
  // word lands; a redirect always wins over pushing or starting a refill.
  task automatic model_step(input bit r, input bit full, input bit clr,
                            input logic [31:0] cpc, input bit done);
    bit hit;
    if (!r) return;
    hit   = cvalid[slot(m_pc)];
    m_vld = 1'b0;
    if (m_req) begin
      if (clr) m_pc = cpc;
      if (done) begin
        m_req = 1'b0;
        cvalid[slot(m_mpc)] = 1'b1;
      end
    end else if (clr) begin
      m_pc = cpc;
    end else if (!hit) begin
      m_req = 1'b1;
      m_mpc = m_pc;
    end else if (!full) begin
      m_vld  = 1'b1;
      m_inst = word_at(m_pc);
      m_ipc  = m_pc;
      m_pc   = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    check_eq("icache_pc", bus.icache_pc_out, m_pc);
    check_eq("iq_valid",  32'(bus.iq_valid_out), 32'(m_vld));
    check_eq("iq_inst",   bus.iq_inst_out, m_inst);
    check_eq("iq_pc",     bus.iq_pc_out, m_ipc);
    check_eq("mem_req",   32'(bus.mem_req_out), 32'(m_req));
    check_eq("mem_pc",    bus.mem_pc_out, m_mpc);
  endtask

  // done_ctl: -1 lets the memory stub answer after a random latency,
  // 0/1 force the done input for this cycle.
  task automatic tick(input bit r, input bit full, input bit clr,
                      input logic [31:0] cpc, input int done_ctl);
    bit          done;
    logic [31:0] lpc;
    if (done_ctl >= 0) begin
      done = done_ctl[0];
      mcnt = -1;
    end else if (!m_req) begin
      done = 1'b0;
      mcnt = -1;
    end else begin
      if (mcnt < 0) mcnt = int'($urandom_range(0, 5));
      if (mcnt == 0) begin
        done = 1'b1;
        mcnt = -1;
      end else begin
        done = 1'b0;
        mcnt--;
      end
    end
    lpc = bus.icache_pc_out;
    rdy                = r;
    bus.iq_full_in     = full;
    bus.clear_in       = clr;
    bus.clear_pc_in    = cpc;
    bus.mem_done_in    = done;
    bus.icache_miss_in = !cvalid[slot(lpc)];
    bus.icache_inst_in = word_at(lpc);
    @(posedge clk);
    @(negedge clk);
    model_step(r, full, clr, cpc, done);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.icache_inst_in = '0;
    bus.icache_miss_in = 1'b0;
    bus.mem_done_in    = 1'b0;
    bus.iq_full_in     = 1'b0;
    bus.clear_in       = 1'b0;
    bus.clear_pc_in    = '0;
    for (int i = 0; i < 1024; i++) cvalid[i] = 1'b0;
    for (int i = 0; i < 32; i++) cvalid[i] = 1'b1;          // 0x000-0x07C
    for (int i = 256; i < 260; i++) cvalid[i] = 1'b1;       // 0x400-0x40C
    cvalid[1022] = 1'b1;                                     // 0xFFFFFFF8
    cvalid[1023] = 1'b1;                                     // 0xFFFFFFFC
    model_reset();

    repeat (3) @(negedge clk);
    check_eq("rst_icache_pc", bus.icache_pc_out, 32'h0);
    check_eq("rst_iq_valid",  32'(bus.iq_valid_out), 32'h0);
    check_eq("rst_iq_inst",   bus.iq_inst_out, 32'h0);
    check_eq("rst_iq_pc",     bus.iq_pc_out, 32'h0);
    check_eq("rst_mem_req",   32'(bus.mem_req_out), 32'h0);
    check_eq("rst_mem_pc",    bus.mem_pc_out, 32'h0);
    rst_n = 1'b1;

    // Back-to-back hits from reset.
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0, 0);
      check_eq("stream_vld", 32'(bus.iq_valid_out), 32'h1);
      check_eq("stream_pc",  bus.iq_pc_out, 32'(i * 4));
    end

    // Redirect colliding with a hit at 0x10.
    tick(1, 0, 1, 32'h40, 0);
    check_eq("clr_hit_nopush", 32'(bus.iq_valid_out), 32'h0);
    tick(1, 0, 0, 0, 0);
    check_eq("clr_hit_pc", bus.iq_pc_out, 32'h40);

    // Queue full on a hit at 0x20.
    tick(1, 0, 1, 32'h20, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0, 0);
      check_eq("full_hold_pc", bus.icache_pc_out, 32'h20);
    end
    tick(1, 0, 0, 0, 0);
    check_eq("full_release_pc", bus.iq_pc_out, 32'h20);

    // Miss at 0x100 with done five cycles after the request.
    tick(1, 0, 1, 32'h100, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0, 0);
      check_eq("miss_req_held", bus.mem_pc_out, 32'h100);
    end
    tick(1, 0, 0, 0, 1);
    check_eq("miss_req_drop", 32'(bus.mem_req_out), 32'h0);
    tick(1, 0, 0, 0, 0);
    check_eq("miss_push_pc", bus.iq_pc_out, 32'h100);

    // Redirect to 0x400 while the miss on 0x80 is outstanding.
    tick(1, 0, 1, 32'h80, 0);
    check_eq("clr_miss_noreq", 32'(bus.mem_req_out), 32'h0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 32'h400, 0);
    check_eq("drain_mem_pc", bus.mem_pc_out, 32'h80);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    check_eq("drain_push_pc", bus.iq_pc_out, 32'h400);

    // Stall with a done pulse while frozen.
    tick(1, 0, 1, 32'h200, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, (i == 1) ? 1 : 0);
      check_eq("frozen_req", 32'(bus.mem_req_out), 32'h1);
    end
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    check_eq("frozen_push_pc", bus.iq_pc_out, 32'h200);

    // pc wrap at the top of the address space.
    tick(1, 0, 1, 32'hFFFF_FFF8, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check_eq("wrap_push_pc", bus.iq_pc_out, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) cvalid[$urandom_range(0, 1023)] = 1'b0;
      tick(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0), {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, -1);
    end

    // Asynchronous reset while a refill is outstanding.
    cvalid[slot(32'h300)] = 1'b0;
    tick(1, 0, 1, 32'h300, 0);
    tick(1, 0, 0, 0, 0);
    check_eq("pre_rst_req", 32'(bus.mem_req_out), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_req",  32'(bus.mem_req_out), 32'h0);
    check_eq("async_rst_pc",   bus.icache_pc_out, 32'h0);
    check_eq("async_rst_vld",  32'(bus.iq_valid_out), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
